// File: rtl/dilithium_pkg.sv
// Shared Dilithium constants and the ExpandA controller state encoding.
package dilithium_pkg;

  localparam int DILITHIUM_N        = 256;
  localparam int DILITHIUM_SAMPLE_W = 23;
  localparam int DILITHIUM_BUS_W    = 4;

  // Matrix A dimensions per security level
  localparam int DILITHIUM2_K = 4;
  localparam int DILITHIUM2_L = 4;
  localparam int DILITHIUM3_K = 6;
  localparam int DILITHIUM3_L = 5;
  localparam int DILITHIUM5_K = 8;
  localparam int DILITHIUM5_L = 7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEED  = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_NEXT  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/expand_a_addr_gen.sv
// Row/column/beat counters for ExpandA and the linear beat address they imply.
module expand_a_addr_gen
  import dilithium_pkg::*;
#(
  parameter int K      = 6,
  parameter int L      = 5,
  parameter int BUS_W  = DILITHIUM_BUS_W,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_all,
  input  logic              beat_clr,
  input  logic              beat_inc,
  input  logic              poly_next,
  output logic [2:0]        idx_i,
  output logic [2:0]        idx_j,
  output logic              last_beat,
  output logic              last_poly,
  output logic [ADDR_W-1:0] addr
);

  localparam int BEATS  = DILITHIUM_N / BUS_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [BEAT_W-1:0] beat;

  always_ff @(posedge clk) begin
    if (rst || clr_all) begin
      idx_i <= 3'd0;
      idx_j <= 3'd0;
      beat  <= '0;
    end else begin
      if (beat_clr)
        beat <= '0;
      else if (beat_inc)
        beat <= beat + BEAT_W'(1);
      // After the final polynomial both indices fold back to zero
      if (poly_next) begin
        if (idx_j == 3'(L - 1)) begin
          idx_j <= 3'd0;
          idx_i <= (idx_i == 3'(K - 1)) ? 3'd0 : idx_i + 3'd1;
        end else begin
          idx_j <= idx_j + 3'd1;
        end
      end
    end
  end

  assign last_beat = (beat == BEAT_W'(BEATS - 1));
  assign last_poly = (idx_i == 3'(K - 1)) && (idx_j == 3'(L - 1));
  assign addr      = ADDR_W'((int'(idx_i) * L + int'(idx_j)) * BEATS + int'(beat));

endmodule

// File: rtl/expand_a_ctrl.sv
// ExpandA controller: seeds the XOF per polynomial and streams sampler beats to memory.
// Optional busy-cycle counter on port cyc_cnt when EXPANDA_PERF_CNT_EN is defined.
module expand_a_ctrl
  import dilithium_pkg::*;
#(
  parameter int K        = 6,
  parameter int L        = 5,
  parameter int SAMPLE_W = DILITHIUM_SAMPLE_W,
  parameter int BUS_W    = DILITHIUM_BUS_W,
  parameter int ADDR_W   = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      xof_start,
  output logic [15:0]               xof_nonce,
  input  logic                      xof_ack,
  output logic                      xof_abort,
  output logic                      smp_flush,
  input  logic                      smp_valid,
  output logic                      smp_ready,
  input  logic [SAMPLE_W*BUS_W-1:0] smp_data,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [SAMPLE_W*BUS_W-1:0] mem_wdata,
  input  logic                      mem_stall,
`ifdef EXPANDA_PERF_CNT_EN
  output logic [31:0]               cyc_cnt,
`endif
  output state_t                    dbg_state
);

  state_t            state, state_nxt;
  logic              accept, last_beat, last_poly, rst_mid;
  logic [2:0]        idx_i, idx_j;
  logic [ADDR_W-1:0] beat_addr;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_SEED;
      ST_SEED:  if (xof_ack) state_nxt = ST_RUN;
      ST_RUN:   if (accept && last_beat) state_nxt = ST_FLUSH;
      ST_FLUSH: state_nxt = ST_NEXT;
      ST_NEXT:  state_nxt = last_poly ? ST_DONE : ST_SEED;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Sampler handshake: a beat transfers on a rising edge where smp_valid and
  // smp_ready are both high; ready is only offered in RUN while memory can take a write.
  assign smp_ready = (state == ST_RUN) && !mem_stall;
  assign accept    = smp_valid && smp_ready;

  assign busy      = (state inside {ST_SEED, ST_RUN, ST_FLUSH, ST_NEXT});
  assign done      = (state == ST_DONE);
  assign xof_start = (state == ST_SEED);
  assign xof_nonce = {5'd0, idx_i, 5'd0, idx_j};
  assign dbg_state = state;

  // A reset that interrupts a run leaves sampler/XOF state behind; clean it up
  // on the first cycle out of reset.
  always_ff @(posedge clk) begin
    if (rst) rst_mid <= rst_mid || (state != ST_IDLE);
    else     rst_mid <= 1'b0;
  end

  assign xof_abort = (state == ST_FLUSH) || (rst_mid && !rst);
  assign smp_flush = xof_abort;

  // Write stage: a pending write is held while memory stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (accept) begin
      mem_we    <= 1'b1;
      mem_addr  <= beat_addr;
      mem_wdata <= smp_data;
    end else if (!mem_stall) begin
      mem_we    <= 1'b0;
    end
  end

  expand_a_addr_gen #(
    .K      (K),
    .L      (L),
    .BUS_W  (BUS_W),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .clr_all   ((state == ST_IDLE) && start),
    .beat_clr  ((state == ST_SEED) && xof_ack),
    .beat_inc  (accept),
    .poly_next (state == ST_NEXT),
    .idx_i     (idx_i),
    .idx_j     (idx_j),
    .last_beat (last_beat),
    .last_poly (last_poly),
    .addr      (beat_addr)
  );

`ifdef EXPANDA_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      cyc_cnt <= '0;
    else if ((state == ST_IDLE) && start)
      cyc_cnt <= '0;
    else if (busy && (cyc_cnt != 32'hFFFF_FFFF))
      cyc_cnt <= cyc_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_expand_a_ctrl.sv
// Directed self-checking bench for expand_a_ctrl (K=6, L=5, BUS_W=4).
`timescale 1ns/1ps
module tb_expand_a_ctrl;
  import dilithium_pkg::*;

  localparam int K     = 6;
  localparam int L     = 5;
  localparam int SW    = 23;
  localparam int BW    = 4;
  localparam int AW    = 12;
  localparam int DW    = SW * BW;
  localparam int BEATS = 256 / BW;
  localparam int TOTAL = K * L * BEATS;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          xof_ack = 1'b0;
  logic          smp_valid = 1'b0;
  logic          mem_stall = 1'b0;
  logic [DW-1:0] smp_data = '0;
  logic          busy, done, xof_start, xof_abort, smp_flush, smp_ready, mem_we;
  logic [15:0]   xof_nonce;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  state_t        dbg_state;
`ifdef EXPANDA_PERF_CNT_EN
  logic [31:0]   cyc_cnt;
`endif

  expand_a_ctrl #(.K(K), .L(L), .SAMPLE_W(SW), .BUS_W(BW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .xof_start (xof_start),
    .xof_nonce (xof_nonce),
    .xof_ack   (xof_ack),
    .xof_abort (xof_abort),
    .smp_flush (smp_flush),
    .smp_valid (smp_valid),
    .smp_ready (smp_ready),
    .smp_data  (smp_data),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_stall (mem_stall),
`ifdef EXPANDA_PERF_CNT_EN
    .cyc_cnt   (cyc_cnt),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  logic [AW+DW-1:0] exp_q[$];

  int   ack_delay = 1;
  int   gap_mode = 0;
  int   seq = 0;
  int   samp_cyc = 0;
  logic samp_hs = 1'b0;
  logic stall_armed = 1'b0;
  int   stall_addr = 0;
  logic mon_en = 1'b0;

  int wr_cnt, xs_cnt, done_cnt, abort_cnt, busy_cyc, first_p5, last_wr_addr, xs_len;
  logic [15:0]   nonce_p5, last_nonce, prev_nonce, exp_nonce;
  logic          prev_xs = 1'b0, prev_hold = 1'b0;
  logic [AW-1:0] hold_addr;
  logic [DW-1:0] hold_data;
  logic [AW+DW-1:0] exp_w;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat_data(input int n);
    logic [DW-1:0] d;
    d = '0;
    for (int l = 0; l < BW; l++) d[l*SW +: SW] = SW'((n * BW + l) * 40503 + 17);
    return d;
  endfunction

  // ---------------- driver tasks / responders ----------------
  // Hash core: acknowledges xof_start on its ack_delay-th cycle.
  initial begin
    int n;
    n = 0;
    forever begin
      @(posedge clk); #1;
      if (xof_start) begin
        n++;
        xof_ack = (n == ack_delay);
      end else begin
        n = 0;
        xof_ack = 1'b0;
      end
    end
  end

  // Sampler: offers beat number seq; advances after each completed handshake.
  initial begin
    forever begin
      @(negedge clk);
      samp_hs = smp_valid && smp_ready;
      @(posedge clk); #1;
      samp_cyc++;
      if (samp_hs) seq++;
      smp_valid = (gap_mode == 0) || (samp_cyc % 5 != 2);
      smp_data  = beat_data(seq);
    end
  end

  // Memory: one-shot 3-cycle stall when the armed address is being written.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (stall_armed && mem_we && (mem_addr == AW'(stall_addr))) begin
        stall_armed = 1'b0;
        mem_stall   = 1'b1;
        repeat (3) @(posedge clk);
        #1 mem_stall = 1'b0;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Model: one start must produce writes to addresses 0..TOTAL-1 in order, each
  // carrying the sampler beats in the order they were offered.
  task automatic prepare_run();
    exp_q.delete();
    for (int n = 0; n < TOTAL; n++) exp_q.push_back({AW'(n), beat_data(n)});
    seq = 0; wr_cnt = 0; xs_cnt = 0; done_cnt = 0; abort_cnt = 0; busy_cyc = 0;
    first_p5 = -1; last_wr_addr = -1;
  endtask

  task automatic wait_done(input int budget, input string name);
    int c;
    c = 0;
    while (!done && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk({name, "_done_seen"}, done, 1'b1);
  endtask

  task automatic end_of_run(input string name);
    repeat (4) @(negedge clk);
    chk({name, "_writes"}, wr_cnt, TOTAL);
    chk({name, "_exp_q_left"}, exp_q.size(), 0);
    chk({name, "_done_pulses"}, done_cnt, 1);
    chk({name, "_xof_starts"}, xs_cnt, K * L);
    chk({name, "_aborts"}, abort_cnt, K * L);
    chk({name, "_busy_after"}, busy, 1'b0);
`ifdef EXPANDA_PERF_CNT_EN
    chk({name, "_cyc_cnt"}, cyc_cnt, busy_cyc);
`endif
  endtask

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_hold) begin
        chk("stall_hold_we", mem_we, 1'b1);
        chk("stall_hold_addr", mem_addr, hold_addr);
        chk("stall_hold_data", mem_wdata, hold_data);
      end
      prev_hold = mem_we && mem_stall;
      hold_addr = mem_addr;
      hold_data = mem_wdata;

      if (mem_we && !mem_stall) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_write: addr %0d written, no write expected", mem_addr);
        end else begin
          exp_w = exp_q.pop_front();
          chk("wr_addr", mem_addr, exp_w[AW+DW-1:DW]);
          chk("wr_data", mem_wdata, exp_w[DW-1:0]);
        end
        if (xs_cnt == 6 && first_p5 < 0) first_p5 = int'(mem_addr);
        last_wr_addr = int'(mem_addr);
        wr_cnt++;
      end

      if (xof_start && !prev_xs) begin
        exp_nonce = 16'(((xs_cnt / L) << 8) + (xs_cnt % L));
        chk("nonce", xof_nonce, exp_nonce);
        if (xs_cnt == 5) nonce_p5 = xof_nonce;
        last_nonce = xof_nonce;
        xs_cnt++;
        xs_len = 1;
      end else if (xof_start) begin
        chk("nonce_stable", xof_nonce, prev_nonce);
        xs_len++;
      end else if (prev_xs) begin
        chk("xof_start_len", xs_len, ack_delay);
      end
      prev_xs    = xof_start;
      prev_nonce = xof_nonce;

      chk("ready_during_stall", smp_ready && mem_stall, 1'b0);
      chk("ready_during_seed", smp_ready && xof_start, 1'b0);
      chk("flush_eq_abort", smp_flush, xof_abort);
      if (done) begin
        chk("busy_in_done", busy, 1'b0);
        done_cnt++;
      end
      if (xof_abort) abort_cnt++;
      if (busy) busy_cyc++;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_xof_start", xof_start, 1'b0);
    chk("rst_xof_abort", xof_abort, 1'b0);
    chk("rst_smp_ready", smp_ready, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    chk("idle_busy", busy, 1'b0);

    // Full matrix, immediate ack, no stall, sampler always valid
    ack_delay = 1; gap_mode = 0;
    prepare_run();
    pulse_start();
    @(negedge clk);
    chk("busy_after_start", busy, 1'b1);
    chk("seed_after_start", xof_start, 1'b1);
    wait_done(5000, "run1");
    end_of_run("run1");
    chk("run1_nonce_after_i0j4", nonce_p5, 16'h0100);
    chk("run1_addr_after_i0j4", first_p5, 320);
    chk("run1_last_nonce", last_nonce, 16'h0504);
    chk("run1_last_addr", last_wr_addr, TOTAL - 1);

    // Slow ack, sampler gaps, stall on beat 10, stray start during RUN
    ack_delay = 5; gap_mode = 1; stall_addr = 10; stall_armed = 1'b1;
    prepare_run();
    pulse_start();
    repeat (100) @(negedge clk);
    chk("run2_in_run", busy && !xof_start, 1'b1);
    pulse_start();
    wait_done(10000, "run2");
    end_of_run("run2");
    chk("run2_stall_fired", stall_armed, 1'b0);

    // Reset at beat 30 of polynomial 7, then a clean restart
    ack_delay = 2; gap_mode = 0;
    prepare_run();
    pulse_start();
    begin
      int c;
      c = 0;
      while (wr_cnt < 7 * BEATS + 30 && c < 3000) begin
        @(negedge clk);
        c++;
      end
    end
    chk("run3_reached_poly7", wr_cnt >= 7 * BEATS + 30, 1'b1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_smp_ready", smp_ready, 1'b0);
    chk("midrst_mem_we", mem_we, 1'b0);
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_mem_wdata", mem_wdata, 0);
    chk("midrst_xof_abort", xof_abort, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("postrst_xof_abort", xof_abort, 1'b1);
    chk("postrst_smp_flush", smp_flush, 1'b1);
    @(negedge clk);
    chk("postrst_abort_once", xof_abort, 1'b0);
    chk("postrst_flush_once", smp_flush, 1'b0);
    chk("postrst_idle", busy, 1'b0);

    prepare_run();
    pulse_start();
    wait_done(5000, "run4");
    end_of_run("run4");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
